// File: rtl/env_pkg.sv
// Shared raster geometry (default 640x480@60 timing) and the scan position type.
package env_pkg;
  localparam int PIXELS_X = 640;
  localparam int PIXELS_Y = 480;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int X_bits   = 10;
  localparam int Y_bits   = 10;

  localparam int H_TOTAL = PIXELS_X + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = PIXELS_Y + V_FRONT + V_SYNC + V_BACK;

  typedef struct packed {
    logic [X_bits-1:0] x;
    logic [Y_bits-1:0] y;
  } scan_pos_t;
endpackage

// File: rtl/vga_scan_gen_if.sv
// Raster timing bundle from the scan generator to the display path.
// NextX/NextY exist only when PREFETCH_EN is defined.
interface vga_scan_gen_if;
  import env_pkg::*;

  logic              pix_tick;
  logic [X_bits-1:0] DrawX;
  logic [Y_bits-1:0] DrawY;
  logic              hs;
  logic              vs;
  logic              blank_n;
  logic              line_start;
  logic              frame_start;
`ifdef PREFETCH_EN
  logic [X_bits-1:0] NextX;
  logic [Y_bits-1:0] NextY;

  modport master (output pix_tick, DrawX, DrawY, hs, vs, blank_n,
                         line_start, frame_start, NextX, NextY);
  modport slave  (input  pix_tick, DrawX, DrawY, hs, vs, blank_n,
                         line_start, frame_start, NextX, NextY);
`else
  modport master (output pix_tick, DrawX, DrawY, hs, vs, blank_n,
                         line_start, frame_start);
  modport slave  (input  pix_tick, DrawX, DrawY, hs, vs, blank_n,
                         line_start, frame_start);
`endif
endinterface

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a registered one-Clk pixel tick every DIV clocks.
module pixel_tick_div #(
  parameter int DIV = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic pix_tick
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] r_div;
  logic          w_last;

  assign w_last = (r_div == DW'(DIV - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_div    <= '0;
      pix_tick <= 1'b0;
    end else begin
      r_div    <= w_last ? '0 : r_div + 1'b1;
      pix_tick <= w_last;
    end
  end
endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: scan position, syncs, blanking and line/frame strobes.
// Optional PREFETCH_EN adds a look-ahead position LEAD ticks ahead of DrawX/DrawY.
module vga_scan_gen #(
  parameter int PIXELS_X = env_pkg::PIXELS_X,
  parameter int PIXELS_Y = env_pkg::PIXELS_Y,
  parameter int H_FRONT  = env_pkg::H_FRONT,
  parameter int H_SYNC   = env_pkg::H_SYNC,
  parameter int H_BACK   = env_pkg::H_BACK,
  parameter int V_FRONT  = env_pkg::V_FRONT,
  parameter int V_SYNC   = env_pkg::V_SYNC,
  parameter int V_BACK   = env_pkg::V_BACK,
  parameter int DIV      = 2
`ifdef PREFETCH_EN
  , parameter int LEAD   = 2
`endif
) (
  input  logic           Clk,
  input  logic           Reset_n,
  vga_scan_gen_if.master o_scan
);
  import env_pkg::*;

  localparam int HT     = PIXELS_X + H_FRONT + H_SYNC + H_BACK;
  localparam int VT     = PIXELS_Y + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG = PIXELS_X + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = PIXELS_Y + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;

  logic      w_tick;
  scan_pos_t r_pos, w_pos_nxt;
  logic      r_hs, r_vs, r_blank_n, r_line, r_frame;

  pixel_tick_div #(.DIV(DIV)) u_div (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .pix_tick (w_tick)
  );

  // One raster step; shared by the display and look-ahead counters so their wraps agree.
  function automatic scan_pos_t scan_step(input scan_pos_t p);
    scan_pos_t n;
    n = p;
    if (p.x == X_bits'(HT - 1)) begin
      n.x = '0;
      n.y = (p.y == Y_bits'(VT - 1)) ? '0 : p.y + 1'b1;
    end else begin
      n.x = p.x + 1'b1;
    end
    return n;
  endfunction

  assign w_pos_nxt = w_tick ? scan_step(r_pos) : r_pos;

  // Decode from the next position so every output lands with the counters it describes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pos     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b1;
      r_line    <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_pos     <= w_pos_nxt;
      r_hs      <= !(w_pos_nxt.x >= X_bits'(HS_BEG) && w_pos_nxt.x < X_bits'(HS_END));
      r_vs      <= !(w_pos_nxt.y >= Y_bits'(VS_BEG) && w_pos_nxt.y < Y_bits'(VS_END));
      r_blank_n <= (w_pos_nxt.x < X_bits'(PIXELS_X)) && (w_pos_nxt.y < Y_bits'(PIXELS_Y));
      r_line    <= w_tick && (w_pos_nxt.x == '0) && (w_pos_nxt.y < Y_bits'(PIXELS_Y));
      r_frame   <= w_tick && (w_pos_nxt == '0);
    end
  end

  assign o_scan.pix_tick    = w_tick;
  assign o_scan.DrawX       = r_pos.x;
  assign o_scan.DrawY       = r_pos.y;
  assign o_scan.hs          = r_hs;
  assign o_scan.vs          = r_vs;
  assign o_scan.blank_n     = r_blank_n;
  assign o_scan.line_start  = r_line;
  assign o_scan.frame_start = r_frame;

`ifdef PREFETCH_EN
  scan_pos_t r_npos;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_npos.x <= X_bits'(LEAD);
      r_npos.y <= '0;
    end else if (w_tick) begin
      r_npos <= scan_step(r_npos);
    end
  end

  assign o_scan.NextX = r_npos.x;
  assign o_scan.NextY = r_npos.y;
`endif
endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: default 640x480 geometry at DIV=2 for line timing, plus a tiny
// 16x9-total geometry at DIV=1 so whole frames and mid-frame reset fit in a short run.
module tb_vga_scan_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   e = 0;

  always #5 clk = ~clk;

  vga_scan_gen_if big_if ();
  vga_scan_gen_if sm_if ();

  vga_scan_gen u_big (
    .Clk     (clk),
    .Reset_n (rst_n),
    .o_scan  (big_if)
  );

  vga_scan_gen #(
    .PIXELS_X(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .PIXELS_Y(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .DIV(1)
  ) u_sm (
    .Clk     (clk),
    .Reset_n (rst_n),
    .o_scan  (sm_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  // Big DUT reaches pixel position p just after release edge 2p+1.
  task automatic goto_big(input int p);
    clk_n(2 * p + 1 - e);
  endtask

  initial begin
    int hs_lo, bl_lo, ls_cnt, vs_lo, tick_lo, fs_cnt, fs_t, ls_vbl, found;
    logic [20:0] fs_snap;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("big_rst_x", big_if.DrawX, 0);
    chk("big_rst_y", big_if.DrawY, 0);
    chk("big_rst_flags", {big_if.pix_tick, big_if.hs, big_if.vs, big_if.blank_n,
                          big_if.line_start, big_if.frame_start}, 6'b011100);
    chk("sm_rst_flags", {sm_if.pix_tick, sm_if.hs, sm_if.vs, sm_if.blank_n,
                         sm_if.line_start, sm_if.frame_start}, 6'b011100);
`ifdef PREFETCH_EN
    chk("big_rst_next", {big_if.NextX, big_if.NextY}, {10'd2, 10'd0});
`endif

    @(negedge clk);
    rst_n = 1'b1;
    e = 0;

    // Divider phase and first steps
    clk_n(1);
    chk("big_e1_tick", big_if.pix_tick, 0);
    chk("sm_e1_tick", sm_if.pix_tick, 1);
    chk("sm_e1_x", sm_if.DrawX, 0);
    clk_n(1);
    chk("big_e2_tick", big_if.pix_tick, 1);
    chk("big_e2_x", big_if.DrawX, 0);
    chk("sm_e2_x", sm_if.DrawX, 1);
    clk_n(1);
    chk("big_e3_tick", big_if.pix_tick, 0);
    chk("big_e3_x", big_if.DrawX, 1);
    goto_big(2);
    chk("big_x2", big_if.DrawX, 2);

    // Line 0 blanking / hsync edges
    goto_big(639); chk("blank_639", big_if.blank_n, 1);
    goto_big(640); chk("blank_640", big_if.blank_n, 0);
    goto_big(655); chk("hs_655", big_if.hs, 1);
    goto_big(656); chk("hs_656", big_if.hs, 0);
    goto_big(751); chk("hs_751", big_if.hs, 0);
    goto_big(752); chk("hs_752", big_if.hs, 1);
    goto_big(799);
    chk("wrap_pre", {big_if.DrawX, big_if.DrawY, big_if.line_start}, {10'd799, 10'd0, 1'b0});
    goto_big(800);
    chk("wrap_post", {big_if.DrawX, big_if.DrawY}, {10'd0, 10'd1});
    chk("wrap_flags", {big_if.line_start, big_if.frame_start, big_if.blank_n, big_if.hs}, 4'b1011);
    clk_n(1);
    chk("ls_one_clk", {big_if.line_start, big_if.DrawX}, {1'b0, 10'd0});

    // Whole of line 1 plus entry to line 2, sampled every clock
    hs_lo = 0; bl_lo = 0; ls_cnt = 0;
    for (int k = 0; k < 1600; k++) begin
      @(posedge clk); e++; #1;
      if (!big_if.hs) hs_lo++;
      if (!big_if.blank_n) bl_lo++;
      if (big_if.line_start) ls_cnt++;
    end
    chk("line1_hs_lo_clks", hs_lo, 192);
    chk("line1_blank_lo_clks", bl_lo, 320);
    chk("line1_ls_clks", ls_cnt, 1);
    chk("line2_pos", {big_if.DrawX, big_if.DrawY}, {10'd0, 10'd2});

    goto_big(5 * 800 + 798);
    chk("big_798_5", {big_if.DrawX, big_if.DrawY}, {10'd798, 10'd5});
`ifdef PREFETCH_EN
    chk("next_798_5", {big_if.NextX, big_if.NextY}, {10'd0, 10'd6});
`endif

    // Mid-frame reset on the small DUT, inside both sync pulses
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(posedge clk); #1;
      if (sm_if.DrawX == 10'd11 && sm_if.DrawY == 10'd5) found = 1;
    end
    chk("sm_find_11_5", found, 1);
    chk("sm_pre_rst", {sm_if.hs, sm_if.vs, sm_if.blank_n}, 3'b000);
    #1 rst_n = 1'b0;
    #1;
    chk("sm_async_rst_pos", {sm_if.DrawX, sm_if.DrawY}, 20'd0);
    chk("sm_async_rst_flags", {sm_if.pix_tick, sm_if.hs, sm_if.vs, sm_if.blank_n,
                               sm_if.line_start, sm_if.frame_start}, 6'b011100);
    @(negedge clk);
    rst_n = 1'b1;

    // One full small frame (144 ticks) after release
    vs_lo = 0; hs_lo = 0; ls_cnt = 0; tick_lo = 0; fs_cnt = 0; fs_t = -1; ls_vbl = 0;
    fs_snap = '0;
    for (int m = 1; m <= 145; m++) begin
      @(posedge clk); #1;
      if (m == 2)
        chk("sm_first_tick_pos", {sm_if.DrawX, sm_if.DrawY}, {10'd1, 10'd0});
`ifdef PREFETCH_EN
      if (m == 144) begin
        chk("sm_last_pos", {sm_if.DrawX, sm_if.DrawY}, {10'd15, 10'd8});
        chk("sm_last_next", {sm_if.NextX, sm_if.NextY}, {10'd1, 10'd0});
      end
`endif
      if (!sm_if.pix_tick) tick_lo++;
      if (!sm_if.vs) vs_lo++;
      if (!sm_if.hs) hs_lo++;
      if (sm_if.line_start) begin
        ls_cnt++;
        if (sm_if.DrawY >= 10'd4) ls_vbl++;
      end
      if (sm_if.frame_start) begin
        fs_cnt++;
        if (fs_t < 0) fs_t = m - 1;
        fs_snap = {sm_if.DrawX, sm_if.DrawY, sm_if.line_start};
      end
    end
    chk("sm_div1_tick_lo", tick_lo, 0);
    chk("sm_vs_lo_clks", vs_lo, 32);
    chk("sm_hs_lo_clks", hs_lo, 27);
    chk("sm_ls_cnt", ls_cnt, 4);
    chk("sm_ls_in_vblank", ls_vbl, 0);
    chk("sm_fs_cnt", fs_cnt, 1);
    chk("sm_fs_ticks", fs_t, 144);
    chk("sm_fs_pos_ls", fs_snap, {10'd0, 10'd0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
